// File: rtl/axis_fifo_if.sv
// AXI4-Stream handshake bundle (tdata/tvalid/tready) used on both sides of axis_fifo.
`timescale 1ns/1ps
interface axis_fifo_if #(
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;

  modport master (
    output tdata,
    output tvalid,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    output tready
  );
endinterface

// File: rtl/axis_fifo.sv
// First-word-fall-through AXI4-Stream FIFO. Define AXIS_FIFO_COUNT_EN to add the count
// occupancy output; without it the port and its logic are absent.
`timescale 1ns/1ps
module axis_fifo #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned DEPTH_LOG2 = 2
) (
  input  logic                clk,
  input  logic                resetn,
  axis_fifo_if.slave          s,
  axis_fifo_if.master         m
`ifdef AXIS_FIFO_COUNT_EN
  ,
  output logic [DEPTH_LOG2:0] count
`endif
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;

  logic [DATA_W-1:0]   mem [Depth];
  logic [DEPTH_LOG2:0] wptr_q, wptr_d;
  logic [DEPTH_LOG2:0] rptr_q, rptr_d;
  logic                ready_q;
  logic                empty;
  logic                full;
  logic                s_ready;
  logic                wr_en;
  logic                rd_en;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[DEPTH_LOG2] != rptr_q[DEPTH_LOG2]) &&
                 (wptr_q[DEPTH_LOG2-1:0] == rptr_q[DEPTH_LOG2-1:0]);

  // ready_q keeps s_tready low in reset and until the first edge after release;
  // s_tready then depends only on registers, never on m_tready.
  assign s_ready  = ready_q & ~full;
  assign s.tready = s_ready;

  assign m.tvalid = ~empty;
  // Gate with empty so stale or uninitialised storage is never presented.
  assign m.tdata  = empty ? '0 : mem[rptr_q[DEPTH_LOG2-1:0]];

  assign wr_en = s.tvalid & s_ready;
  assign rd_en = ~empty & m.tready;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (wr_en) wptr_d = wptr_q + 1'b1;
    if (rd_en) rptr_d = rptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      ready_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr_q[DEPTH_LOG2-1:0]] <= s.tdata;
  end

`ifdef AXIS_FIFO_COUNT_EN
  assign count = wptr_q - rptr_q;
`endif

endmodule

// File: tb/tb_axis_fifo.sv
// Directed self-checking bench for axis_fifo: reset, fill, drain, streaming,
// backpressure ordering and asynchronous reset mid-stream.
`timescale 1ns/1ps
module tb_axis_fifo;

  logic clk;
  logic resetn;
  int   checks;
  int   errors;

  axis_fifo_if #(.DATA_W(8)) s_if ();
  axis_fifo_if #(.DATA_W(8)) m_if ();

`ifdef AXIS_FIFO_COUNT_EN
  logic [2:0] count;
`endif

  axis_fifo #(
    .DATA_W    (8),
    .DEPTH_LOG2(2)
  ) u_dut (
    .clk   (clk),
    .resetn(resetn),
    .s     (s_if),
    .m     (m_if)
`ifdef AXIS_FIFO_COUNT_EN
    ,
    .count (count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    s_if.tvalid = 1'b1;
    s_if.tdata  = 8'hAA;
    m_if.tready = 1'b0;
    #20;
    checks++;
    if (s_if.tready !== 1'b0) begin
      errors++; $display("FAIL reset_s_tready got %b want 0", s_if.tready);
    end
    checks++;
    if (m_if.tvalid !== 1'b0) begin
      errors++; $display("FAIL reset_m_tvalid got %b want 0", m_if.tvalid);
    end
    checks++;
    if (m_if.tdata !== 8'h00) begin
      errors++; $display("FAIL reset_m_tdata got %h want 00", m_if.tdata);
    end
`ifdef AXIS_FIFO_COUNT_EN
    checks++;
    if (count !== 3'd0) begin
      errors++; $display("FAIL reset_count got %0d want 0", count);
    end
`endif
    s_if.tvalid = 1'b0;
    resetn = 1'b1;
    #1;
    checks++;
    if (s_if.tready !== 1'b0) begin
      errors++; $display("FAIL release_pre_edge_s_tready got %b want 0", s_if.tready);
    end
    step();
    checks++;
    if (s_if.tready !== 1'b1) begin
      errors++; $display("FAIL first_edge_s_tready got %b want 1", s_if.tready);
    end
    checks++;
    if (m_if.tvalid !== 1'b0) begin
      errors++; $display("FAIL first_edge_m_tvalid got %b want 0", m_if.tvalid);
    end
  endtask

  task automatic test_fill();
    m_if.tready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      s_if.tdata  = 8'(i);
      s_if.tvalid = 1'b1;
      step();
      checks++;
      if (m_if.tvalid !== 1'b1 || m_if.tdata !== 8'd1) begin
        errors++;
        $display("FAIL fill_head beat %0d got v=%b d=%0d want v=1 d=1", i, m_if.tvalid,
                 m_if.tdata);
      end
      checks++;
      if (s_if.tready !== (i < 4)) begin
        errors++; $display("FAIL fill_s_tready beat %0d got %b want %b", i, s_if.tready, i < 4);
      end
    end
    s_if.tdata  = 8'd5;
    s_if.tvalid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      checks++;
      if (s_if.tready !== 1'b0 || m_if.tdata !== 8'd1) begin
        errors++;
        $display("FAIL full_hold got rdy=%b d=%0d want rdy=0 d=1", s_if.tready, m_if.tdata);
      end
    end
`ifdef AXIS_FIFO_COUNT_EN
    checks++;
    if (count !== 3'd4) begin
      errors++; $display("FAIL full_count got %0d want 4", count);
    end
`endif
  endtask

  task automatic test_drain();
    logic [7:0] exp_d [4];
    exp_d[0] = 8'd2; exp_d[1] = 8'd3; exp_d[2] = 8'd4; exp_d[3] = 8'd5;
    m_if.tready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      // Beat 5 is written on the second edge; stop offering after that.
      if (k == 1) s_if.tvalid = 1'b0;
      checks++;
      if (m_if.tvalid !== 1'b1 || m_if.tdata !== exp_d[k]) begin
        errors++;
        $display("FAIL drain_%0d got v=%b d=%0d want v=1 d=%0d", k, m_if.tvalid, m_if.tdata,
                 exp_d[k]);
      end
      if (k == 0) begin
        checks++;
        if (s_if.tready !== 1'b1) begin
          errors++; $display("FAIL drain_free_s_tready got %b want 1", s_if.tready);
        end
      end
    end
    step();
    checks++;
    if (m_if.tvalid !== 1'b0 || m_if.tdata !== 8'd0) begin
      errors++;
      $display("FAIL drain_empty got v=%b d=%0d want v=0 d=0", m_if.tvalid, m_if.tdata);
    end
  endtask

  task automatic test_streaming();
    m_if.tready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      s_if.tdata  = 8'(i);
      s_if.tvalid = 1'b1;
      step();
      checks++;
      if (m_if.tvalid !== 1'b1 || m_if.tdata !== 8'(i)) begin
        errors++;
        $display("FAIL stream_%0d got v=%b d=%0d want v=1 d=%0d", i, m_if.tvalid, m_if.tdata, i);
      end
`ifdef AXIS_FIFO_COUNT_EN
      checks++;
      if (count !== 3'd1) begin
        errors++; $display("FAIL stream_count_%0d got %0d want 1", i, count);
      end
`endif
    end
    s_if.tvalid = 1'b0;
    step();
    checks++;
    if (m_if.tvalid !== 1'b0) begin
      errors++; $display("FAIL stream_end_m_tvalid got %b want 0", m_if.tvalid);
    end
  endtask

  task automatic test_backpressure();
    int         send_idx;
    int         exp_out;
    int         cycles;
    logic       wr;
    logic       rd;
    logic       prev_stall;
    logic [7:0] prev_data;
    send_idx   = 0;
    exp_out    = 0;
    cycles     = 0;
    prev_stall = 1'b0;
    prev_data  = 8'd0;
    while (exp_out < 50 && cycles < 600) begin
      s_if.tdata  = 8'(send_idx);
      s_if.tvalid = (send_idx < 50);
      m_if.tready = 1'($urandom_range(0, 1));
      #1;
      if (prev_stall) begin
        checks++;
        if (m_if.tvalid !== 1'b1 || m_if.tdata !== prev_data) begin
          errors++;
          $display("FAIL bp_stable got v=%b d=%0d want v=1 d=%0d", m_if.tvalid, m_if.tdata,
                   prev_data);
        end
      end
      wr = s_if.tvalid & s_if.tready;
      rd = m_if.tvalid & m_if.tready;
      if (rd) begin
        checks++;
        if (m_if.tdata !== 8'(exp_out)) begin
          errors++; $display("FAIL bp_order got %0d want %0d", m_if.tdata, exp_out);
        end
        exp_out++;
      end
      prev_stall = m_if.tvalid & ~m_if.tready;
      prev_data  = m_if.tdata;
      @(posedge clk);
      #1;
      if (wr) send_idx++;
      cycles++;
    end
    checks++;
    if (exp_out !== 50) begin
      errors++; $display("FAIL bp_timeout got %0d beats want 50", exp_out);
    end
    s_if.tvalid = 1'b0;
    m_if.tready = 1'b0;
    step();
    checks++;
    if (m_if.tvalid !== 1'b0) begin
      errors++; $display("FAIL bp_end_m_tvalid got %b want 0", m_if.tvalid);
    end
  endtask

  task automatic test_reset_midstream();
    m_if.tready = 1'b0;
    for (int i = 7; i <= 9; i++) begin
      s_if.tdata  = 8'(i);
      s_if.tvalid = 1'b1;
      step();
    end
    s_if.tvalid = 1'b0;
    #1;
    resetn = 1'b0;
    #1;
    checks++;
    if (m_if.tvalid !== 1'b0 || m_if.tdata !== 8'd0 || s_if.tready !== 1'b0) begin
      errors++;
      $display("FAIL midrst_outputs got v=%b d=%0d rdy=%b want v=0 d=0 rdy=0", m_if.tvalid,
               m_if.tdata, s_if.tready);
    end
`ifdef AXIS_FIFO_COUNT_EN
    checks++;
    if (count !== 3'd0) begin
      errors++; $display("FAIL midrst_count got %0d want 0", count);
    end
`endif
    #2;
    resetn = 1'b1;
    step();
    checks++;
    if (s_if.tready !== 1'b1 || m_if.tvalid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_release got rdy=%b v=%b want rdy=1 v=0", s_if.tready, m_if.tvalid);
    end
    s_if.tdata  = 8'd42;
    s_if.tvalid = 1'b1;
    step();
    s_if.tvalid = 1'b0;
    checks++;
    if (m_if.tvalid !== 1'b1 || m_if.tdata !== 8'd42) begin
      errors++;
      $display("FAIL midrst_first got v=%b d=%0d want v=1 d=42", m_if.tvalid, m_if.tdata);
    end
    m_if.tready = 1'b1;
    step();
    checks++;
    if (m_if.tvalid !== 1'b0) begin
      errors++; $display("FAIL midrst_after got v=%b want 0", m_if.tvalid);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_fill();
    test_drain();
    test_streaming();
    test_backpressure();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
